// File: rtl/obstacle_place_ctrl.sv
// Obstacle placement controller: random cell -> legality check -> map write.
// Optional retry abort is enabled by defining OBS_RETRY_LIMIT_EN.
module obstacle_place_ctrl #(
  parameter int MAX_OBS   = 15,
  parameter int MAX_RETRY = 8
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       enable,
  input  logic       s_reset,
  input  logic       trigger,
  input  logic [7:0] curr_length,
  output logic       rand_req,
  input  logic       rand_valid,
  input  logic [3:0] rand_x,
  input  logic [3:0] rand_y,
  output logic       chk_req,
  output logic [3:0] chk_x,
  output logic [3:0] chk_y,
  input  logic       chk_done,
  input  logic       chk_hit,
  output logic       map_wr,
  output logic [7:0] map_addr,
  output logic       map_clr,
  output logic [3:0] obstacle_count,
  output logic       busy,
  output logic       place_fail
);

  typedef enum logic [1:0] {IDLE, RAND, CHECK, WRITE} state_t;

  state_t     r_state, w_state_next;
  logic [3:0] r_count, r_x, r_y;
  logic       r_pending, r_map_clr;
  logic       w_clear, w_admit, w_start, w_coord_ok, w_abort;
  logic [8:0] w_lhs, w_rhs;
  logic [7:0] w_addr;

  assign w_clear = !enable || s_reset;

  // Density rule keeps the obstacle count below roughly half the snake length.
  assign w_lhs   = ({5'd0, r_count} + 9'd1) << 1;
  assign w_rhs   = {1'b0, curr_length} + 9'd2;
  assign w_admit = !w_clear && (r_count < 4'(MAX_OBS)) &&
                   ((curr_length < 8'd3) || (w_lhs < w_rhs));
  assign w_start = (r_state == IDLE) && (trigger || r_pending) && w_admit;

  // Playfield interior is x 1..14, y 1..10.
  assign w_coord_ok = (rand_x != 4'd0) && (rand_x <= 4'd14) &&
                      (rand_y != 4'd0) && (rand_y <= 4'd10);
  assign w_addr = ({4'd0, r_y} - 8'd1) * 8'd14 + ({4'd0, r_x} - 8'd1);

  assign busy           = (r_state != IDLE);
  assign chk_x          = r_x;
  assign chk_y          = r_y;
  assign obstacle_count = r_count;
  assign map_clr        = r_map_clr;

  always_comb begin
    w_state_next = r_state;
    rand_req     = 1'b0;
    chk_req      = 1'b0;
    map_wr       = 1'b0;
    map_addr     = 8'd0;
    if (w_clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_start) w_state_next = RAND;
        RAND: begin
          rand_req = 1'b1;
          if (rand_valid) begin
            if (w_coord_ok)   w_state_next = CHECK;
            else if (w_abort) w_state_next = IDLE;
          end
        end
        CHECK: begin
          chk_req = 1'b1;
          if (chk_done) begin
            if (!chk_hit)     w_state_next = WRITE;
            else if (w_abort) w_state_next = IDLE;
            else              w_state_next = RAND;
          end
        end
        WRITE: begin
          map_wr       = 1'b1;
          map_addr     = w_addr;
          w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= IDLE;
      r_count   <= 4'd0;
      r_x       <= 4'd0;
      r_y       <= 4'd0;
      r_pending <= 1'b0;
      r_map_clr <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_map_clr <= w_clear;
      if (w_clear) begin
        r_count   <= 4'd0;
        r_pending <= 1'b0;
      end else begin
        if (r_state == RAND && rand_valid) begin
          r_x <= rand_x;
          r_y <= rand_y;
        end
        if (r_state == WRITE && r_count < 4'(MAX_OBS))
          r_count <= r_count + 4'd1;
        // One-deep queue for triggers that arrive while a placement runs.
        if (w_start)
          r_pending <= 1'b0;
        else if (trigger && r_state != IDLE)
          r_pending <= 1'b1;
      end
    end
  end

`ifdef OBS_RETRY_LIMIT_EN
  localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  logic [RETRY_W-1:0] r_retry;
  logic               r_place_fail;
  logic               w_fail_attempt;

  assign w_fail_attempt = (r_state == RAND  && rand_valid && !w_coord_ok) ||
                          (r_state == CHECK && chk_done   && chk_hit);
  assign w_abort    = w_fail_attempt && ((int'(r_retry) + 1) >= MAX_RETRY);
  assign place_fail = r_place_fail;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_retry      <= '0;
      r_place_fail <= 1'b0;
    end else begin
      r_place_fail <= !w_clear && w_abort;
      if (w_clear || w_start || w_abort)
        r_retry <= '0;
      else if (w_fail_attempt)
        r_retry <= r_retry + 1'b1;
    end
  end
`else
  assign w_abort    = 1'b0;
  assign place_fail = 1'b0;
`endif

endmodule

// File: tb/tb_obstacle_place_ctrl.sv
// Directed bench for obstacle_place_ctrl: a cycle model checked every cycle
// plus hand-computed literal expectations for the key scenarios.
module tb_obstacle_place_ctrl;
  localparam int MAX_OBS   = 15;
  localparam int MAX_RETRY = 8;
`ifdef OBS_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       enable = 1'b0, s_reset = 1'b0, trigger = 1'b0;
  logic [7:0] curr_length = 8'd0;
  logic       rand_req, rand_valid = 1'b0;
  logic [3:0] rand_x = 4'd0, rand_y = 4'd0;
  logic       chk_req, chk_done = 1'b0, chk_hit = 1'b0;
  logic [3:0] chk_x, chk_y;
  logic       map_wr, map_clr, busy, place_fail;
  logic [7:0] map_addr;
  logic [3:0] obstacle_count;

  int checks = 0;
  int errors = 0;

  obstacle_place_ctrl #(.MAX_OBS(MAX_OBS), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .nRst(nRst), .enable(enable), .s_reset(s_reset),
    .trigger(trigger), .curr_length(curr_length),
    .rand_req(rand_req), .rand_valid(rand_valid), .rand_x(rand_x), .rand_y(rand_y),
    .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_done(chk_done), .chk_hit(chk_hit),
    .map_wr(map_wr), .map_addr(map_addr), .map_clr(map_clr),
    .obstacle_count(obstacle_count), .busy(busy), .place_fail(place_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase = 0;   // 0 idle, 1 awaiting random cell, 2 awaiting check, 3 writing
  int m_count = 0, m_fails = 0, m_x = 0, m_y = 0;
  bit m_pend = 0, m_clr = 0, m_pfail = 0;

  function automatic bit admitted(input int cnt, input int len);
    return (cnt < MAX_OBS) && ((len < 3) || (2 * (cnt + 1) < len + 2));
  endfunction

  function automatic bit on_board(input int x, input int y);
    return (x >= 1) && (x <= 14) && (y >= 1) && (y <= 10);
  endfunction

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m_phase <= 0; m_count <= 0; m_fails <= 0; m_x <= 0; m_y <= 0;
      m_pend <= 0; m_clr <= 0; m_pfail <= 0;
    end else begin
      m_clr   <= !enable || s_reset;
      m_pfail <= 0;
      if (!enable || s_reset) begin
        m_phase <= 0; m_count <= 0; m_pend <= 0; m_fails <= 0;
      end else begin
        if (m_phase != 0 && trigger) m_pend <= 1;
        if (m_phase == 0) begin
          if ((trigger || m_pend) && admitted(m_count, int'(curr_length))) begin
            m_phase <= 1; m_pend <= 0; m_fails <= 0;
          end
        end else if (m_phase == 1) begin
          if (rand_valid) begin
            m_x <= int'(rand_x); m_y <= int'(rand_y);
            if (on_board(int'(rand_x), int'(rand_y))) m_phase <= 2;
            else if (LIMIT_EN && m_fails + 1 >= MAX_RETRY) begin m_phase <= 0; m_pfail <= 1; end
            else m_fails <= m_fails + 1;
          end
        end else if (m_phase == 2) begin
          if (chk_done) begin
            if (!chk_hit) m_phase <= 3;
            else if (LIMIT_EN && m_fails + 1 >= MAX_RETRY) begin m_phase <= 0; m_pfail <= 1; end
            else begin m_fails <= m_fails + 1; m_phase <= 1; end
          end
        end else begin
          m_phase <= 0;
          if (m_count < MAX_OBS) m_count <= m_count + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (nRst) begin
      bit live;
      live = enable && !s_reset;
      check("busy",      int'(busy),           int'(m_phase != 0));
      check("rand_req",  int'(rand_req),       int'(live && m_phase == 1));
      check("chk_req",   int'(chk_req),        int'(live && m_phase == 2));
      check("map_wr",    int'(map_wr),         int'(live && m_phase == 3));
      check("map_clr",   int'(map_clr),        int'(m_clr));
      check("place_fail",int'(place_fail),     int'(m_pfail));
      check("count",     int'(obstacle_count), m_count);
      if (m_phase == 2) begin
        check("chk_x", int'(chk_x), m_x);
        check("chk_y", int'(chk_y), m_y);
      end
      if (live && m_phase == 3)
        check("map_addr", int'(map_addr), (m_y - 1) * 14 + (m_x - 1));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1; tick(); trigger = 1'b0;
  endtask

  task automatic give_rand(input int x, input int y);
    for (int i = 0; i < 30 && !rand_req; i++) tick();
    if (!rand_req) begin
      check("rand_req_timeout", 0, 1);
      return;
    end
    rand_valid = 1'b1; rand_x = 4'(x); rand_y = 4'(y);
    tick();
    rand_valid = 1'b0;
  endtask

  task automatic give_chk(input bit hit, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30 && !chk_req; i++) tick();
    if (!chk_req) begin
      check("chk_req_timeout", 0, 1);
      return;
    end
    got = 1'b1;
    chk_done = 1'b1; chk_hit = hit;
    tick();
    chk_done = 1'b0; chk_hit = 1'b0;
  endtask

  task automatic place(input int x, input int y);
    bit got;
    pulse_trigger();
    give_rand(x, y);
    give_chk(1'b0, got);
    tick();
    $display("placed obstacle at (%0d,%0d), count now %0d", x, y, obstacle_count);
  endtask

  initial begin
    bit got;
    int hs;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int hs;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",  int'(busy), 0);
    check("reset_count", int'(obstacle_count), 0);
    check("reset_clr",   int'(map_clr), 0);
    nRst = 1'b1;
    tick();
    enable = 1'b1; curr_length = 8'd10;
    tick(); tick();

    // Length 10, count 0: (3,2) -> address 16.
    pulse_trigger();
    check("s1_rand_req", int'(rand_req), 1);
    give_rand(3, 2);
    check("s1_chk_x", int'(chk_x), 3);
    check("s1_chk_y", int'(chk_y), 2);
    give_chk(1'b0, got);
    check("s1_map_wr", int'(map_wr), 1);
    check("s1_map_addr", int'(map_addr), 16);
    tick();
    check("s1_map_wr_off", int'(map_wr), 0);
    check("s1_count", int'(obstacle_count), 1);
    $display("txn1: wrote addr 16, count %0d", obstacle_count);

    // Off-board (15,4) is retried without a check; (5,5) -> address 60.
    pulse_trigger();
    give_rand(15, 4);
    check("s2_no_chk", int'(chk_req), 0);
    check("s2_rerequest", int'(rand_req), 1);
    give_rand(5, 5);
    check("s2_chk_x", int'(chk_x), 5);
    give_chk(1'b0, got);
    check("s2_map_addr", int'(map_addr), 60);
    tick();
    check("s2_count", int'(obstacle_count), 2);
    $display("txn2: wrote addr 60, count %0d", obstacle_count);

    // Second trigger during CHECK is queued, third is dropped.
    pulse_trigger();
    give_rand(2, 2);
    pulse_trigger();
    pulse_trigger();
    give_chk(1'b0, got);
    check("s3_write", int'(map_wr), 1);
    tick();
    check("s3_count", int'(obstacle_count), 3);
    tick();
    check("s3_pending_start", int'(rand_req), 1);
    give_rand(4, 3);
    give_chk(1'b0, got);
    check("s3_addr2", int'(map_addr), 31);
    tick();
    repeat (3) tick();
    check("s3_third_dropped", int'(busy), 0);
    check("s3_count2", int'(obstacle_count), 4);
    $display("txn3: queued placement done, count %0d", obstacle_count);

    // Synchronous game reset during RAND with count 4.
    pulse_trigger();
    check("s4_in_rand", int'(rand_req), 1);
    s_reset = 1'b1; tick(); s_reset = 1'b0;
    check("s4_busy", int'(busy), 0);
    check("s4_count", int'(obstacle_count), 0);
    check("s4_map_clr", int'(map_clr), 1);
    check("s4_rand_req", int'(rand_req), 0);
    tick();
    check("s4_map_clr_off", int'(map_clr), 0);
    $display("txn4: s_reset cleared state");

    // Enable dropped mid CHECK.
    place(1, 1);
    pulse_trigger();
    give_rand(6, 6);
    enable = 1'b0; tick();
    check("s5_chk_req", int'(chk_req), 0);
    check("s5_count", int'(obstacle_count), 0);
    check("s5_map_clr", int'(map_clr), 1);
    enable = 1'b1; tick();
    $display("txn5: enable drop cleared state");

    // Length 4: count 2 blocks the next trigger (6 not < 6).
    curr_length = 8'd4;
    place(2, 1);
    place(3, 1);
    check("s6_count", int'(obstacle_count), 2);
    pulse_trigger();
    check("s6_dropped_req", int'(rand_req), 0);
    check("s6_dropped_busy", int'(busy), 0);
    $display("txn6: density-limited trigger dropped");

    // Fill to the ceiling with a long snake, then the ceiling blocks.
    curr_length = 8'd40;
    for (int i = 0; i < 13; i++) place(1 + i, 1 + (i % 10));
    check("s7_count_full", int'(obstacle_count), 15);
    pulse_trigger();
    check("s7_full_dropped", int'(rand_req), 0);
    repeat (2) tick();
    check("s7_count_sat", int'(obstacle_count), 15);
    $display("txn7: ceiling reached, trigger dropped");

    s_reset = 1'b1; tick(); s_reset = 1'b0; tick();
    curr_length = 8'd10;
    pulse_trigger();
    hs = 0;
`ifdef OBS_RETRY_LIMIT_EN
    for (int k = 0; k < MAX_RETRY; k++) begin
      give_rand(7, 7);
      give_chk(1'b1, got);
      if (got) hs++;
      if (k == MAX_RETRY - 2) check("s8_still_busy", int'(busy), 1);
    end
    check("s8_handshakes", hs, 8);
    check("s8_place_fail", int'(place_fail), 1);
    check("s8_busy", int'(busy), 0);
    check("s8_count", int'(obstacle_count), 0);
    tick();
    check("s8_fail_pulse", int'(place_fail), 0);
    $display("txn8: placement aborted after %0d hits", hs);
`else
    for (int k = 0; k < 10; k++) begin
      give_rand(7, 7);
      give_chk(1'b1, got);
      if (got) hs++;
    end
    check("s8_handshakes", hs, 10);
    check("s8_busy", int'(busy), 1);
    check("s8_no_fail", int'(place_fail), 0);
    give_rand(7, 7);
    give_chk(1'b0, got);
    check("s8_addr", int'(map_addr), 90);
    tick();
    check("s8_count", int'(obstacle_count), 1);
    $display("txn8: placement succeeded after %0d hits", hs);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
